// File: rtl/adpll_pkg.sv
// Shared ADPLL types and helpers: FSM state encoding, default widths and
// saturating/clamping arithmetic reused by the loop filter and DCO driver.
package adpll_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    UPDATE = 3'd4
  } state_t;

  localparam int WIDTH_DEF      = 5;
  localparam int CTRL_WIDTH_DEF = 12;
  localparam int INT_WIDTH_DEF  = 16;
  localparam int CTRL_INIT_DEF  = 2048;

  // Saturate v to the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/adpll_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for asynchronous ADPLL strobes.
// rise_o is a one-cycle pulse in the cycle the synchronised level first reads 1.
module adpll_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/adpll_loop_filter.sv
// ADPLL proportional-integral loop filter: samples the detector error once per
// reference edge and drives a clamped DCO control word. Lock detection is
// compiled in with ADPLL_LOOP_FILTER_LOCK_DETECT_EN.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int CTRL_WIDTH    = CTRL_WIDTH_DEF,
  parameter int INT_WIDTH     = INT_WIDTH_DEF,
  parameter int KP_SHIFT      = 3,
  parameter int KI_SHIFT      = 0,
  parameter int SETTLE_CYCLES = 2,
  parameter int CTRL_INIT     = CTRL_INIT_DEF,
  parameter int LOCK_THRESH   = 1,
  parameter int LOCK_COUNT    = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  reference_i,
  input  logic [WIDTH-1:0]      pd_error_i,
  input  logic                  enable_i,
  output logic [CTRL_WIDTH-1:0] ctrl_word_o,
  output logic                  ctrl_valid_o,
  output logic                  saturated_o,
  output logic                  locked_o,
  output logic [2:0]            state_o
);

  localparam int XW = INT_WIDTH + 2;
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam int CTRL_MAX = (1 << CTRL_WIDTH) - 1;
  localparam logic signed [XW-1:0] INIT_X = XW'(CTRL_INIT);
  localparam logic signed [XW-1:0] MAX_X  = XW'(CTRL_MAX);

  if (SETTLE_CYCLES < 1 || LOCK_COUNT < 1 || LOCK_THRESH < 0) begin : g_bad_param
    $error("adpll_loop_filter: SETTLE_CYCLES and LOCK_COUNT must be >= 1");
  end

  state_t state_q, state_d;
  logic   ref_rise;
  logic [CW-1:0] cnt_q;

  logic signed [INT_WIDTH-1:0]  err_q, integ_q, integ_d, i_next;
  logic signed [XW-1:0]         err_x, i_sum, sum_x;
  logic                         hi_clip, lo_clip, freeze;
  logic [CTRL_WIDTH-1:0]        word_q, word_new;
  logic                         sat_q;

  adpll_sync_edge u_ref_sync (
    .clk_i  (fpga_clk_i),
    .rst_ni (reset_n_i),
    .async_i(reference_i),
    .rise_o (ref_rise)
  );

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (ref_rise) state_d = SETTLE;
        SETTLE:  if (cnt_q == '0) state_d = SAMPLE;
        SAMPLE:  state_d = UPDATE;
        UPDATE:  state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // The new word is presented combinationally during UPDATE so the valid
  // pulse and the data it qualifies share the same cycle.
  always_comb begin
    ctrl_valid_o = (state_q == UPDATE);
    ctrl_word_o  = ctrl_valid_o ? word_new : word_q;
    saturated_o  = ctrl_valid_o ? (hi_clip | lo_clip) : sat_q;
    state_o      = state_q;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (state_q == ARMED) begin
      cnt_q <= CW'(SETTLE_CYCLES - 1);
    end else if (state_q == SETTLE && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_comb begin
    err_x    = XW'(err_q);
    i_sum    = XW'(integ_q) + (err_x <<< KI_SHIFT);
    i_next   = INT_WIDTH'(sat_signed(32'(i_sum), INT_WIDTH));
    sum_x    = INIT_X + XW'(i_next) + (err_x <<< KP_SHIFT);
    hi_clip  = (sum_x > MAX_X);
    lo_clip  = sum_x[XW-1];
    word_new = CTRL_WIDTH'(clamp(32'(sum_x), 32'sd0, 32'(CTRL_MAX)));
    // Anti-windup: stop integrating further into a limit already hit.
    freeze   = (hi_clip && !err_x[XW-1] && (err_x != '0)) || (lo_clip && err_x[XW-1]);
    integ_d  = freeze ? integ_q : i_next;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q   <= '0;
      integ_q <= '0;
      word_q  <= CTRL_WIDTH'(CTRL_INIT);
      sat_q   <= 1'b0;
    end else begin
      if (state_q == SAMPLE) err_q <= INT_WIDTH'($signed(pd_error_i));
      if (state_q == UPDATE) begin
        integ_q <= integ_d;
        word_q  <= word_new;
        sat_q   <= hi_clip | lo_clip;
      end
    end
  end

`ifdef ADPLL_LOOP_FILTER_LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  logic [LCW-1:0]       lock_cnt_q;
  logic signed [XW-1:0] err_abs;
  logic                 in_lock;

  always_comb begin
    err_abs = err_x[XW-1] ? -err_x : err_x;
    in_lock = (err_abs <= XW'(LOCK_THRESH));
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_cnt_q <= '0;
    end else if (!enable_i) begin
      lock_cnt_q <= '0;
    end else if (state_q == UPDATE) begin
      if (!in_lock)                            lock_cnt_q <= '0;
      else if (lock_cnt_q != LCW'(LOCK_COUNT)) lock_cnt_q <= lock_cnt_q + LCW'(1);
    end
  end

  assign locked_o = (lock_cnt_q == LCW'(LOCK_COUNT));
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Bench for adpll_loop_filter: random and directed reference/error stimulus,
// with a queue-based scoreboard fed by an arithmetic model of the PI filter.
module tb_adpll_loop_filter;

  localparam int W     = 5;
  localparam int CW    = 12;
  localparam int S     = 2;
  localparam int KP    = 3;
  localparam int KI    = 0;
  localparam int INIT  = 2048;
  localparam int CMAX  = 4095;
  localparam int IMAX  = 32767;
  localparam int IMIN  = -32768;
  localparam int LTH   = 1;
  localparam int LCNT  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          reference = 1'b0;
  logic [W-1:0]  pd_error = '0;
  logic          enable = 1'b0;
  logic [CW-1:0] ctrl_word;
  logic          ctrl_valid;
  logic          saturated;
  logic          locked;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [CW-1:0] exp_word_q[$];
  logic          exp_sat_q[$];
  logic          exp_lock_q[$];
  int            exp_cyc_q[$];

  // Reference model state
  int m_integ = 0;
  int m_word  = INIT;
  int m_sat   = 0;
  int m_lock  = 0;

  adpll_loop_filter #(
    .WIDTH(W), .CTRL_WIDTH(CW), .INT_WIDTH(16), .KP_SHIFT(KP), .KI_SHIFT(KI),
    .SETTLE_CYCLES(S), .CTRL_INIT(INIT), .LOCK_THRESH(LTH), .LOCK_COUNT(LCNT)
  ) dut (
    .fpga_clk_i  (clk),
    .reset_n_i   (reset_n),
    .reference_i (reference),
    .pd_error_i  (pd_error),
    .enable_i    (enable),
    .ctrl_word_o (ctrl_word),
    .ctrl_valid_o(ctrl_valid),
    .saturated_o (saturated),
    .locked_o    (locked),
    .state_o     (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_integ = 0;
    m_word  = INIT;
    m_sat   = 0;
    m_lock  = 0;
  endfunction

  // PI filter from first principles; pushes the expected response.
  function automatic void model_update(input int err, input int valid_cyc);
    int i_raw, i_next, sum, lock_now;
    bit hi, lo;
    i_raw  = m_integ + err * (1 << KI);
    i_next = (i_raw > IMAX) ? IMAX : (i_raw < IMIN) ? IMIN : i_raw;
    sum    = INIT + i_next + err * (1 << KP);
    hi     = sum > CMAX;
    lo     = sum < 0;
    m_word = hi ? CMAX : lo ? 0 : sum;
    m_sat  = (hi || lo) ? 1 : 0;
    if (!((hi && err > 0) || (lo && err < 0))) m_integ = i_next;
    if (err <= LTH && err >= -LTH) begin
      if (m_lock < LCNT) m_lock++;
    end else begin
      m_lock = 0;
    end
`ifdef ADPLL_LOOP_FILTER_LOCK_DETECT_EN
    lock_now = (m_lock == LCNT) ? 1 : 0;
`else
    lock_now = 0;
`endif
    exp_word_q.push_back(CW'(m_word));
    exp_sat_q.push_back(m_sat[0]);
    exp_lock_q.push_back(lock_now[0]);
    exp_cyc_q.push_back(valid_cyc);
  endfunction

  // Monitor: every valid pulse is matched against the expected queue; the
  // lock flag is checked one cycle later, after the update edge.
  logic lock_pend = 1'b0;
  logic lock_pend_val = 1'b0;
  always @(negedge clk) begin
    if (lock_pend) begin
      check("locked_after_update", int'(locked), int'(lock_pend_val));
      lock_pend = 1'b0;
    end
    if (ctrl_valid) begin
      if (exp_word_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("ctrl_word", int'(ctrl_word), int'(exp_word_q.pop_front()));
        check("saturated", int'(saturated), int'(exp_sat_q.pop_front()));
        check("valid_cycle", cyc, exp_cyc_q.pop_front());
        lock_pend_val = exp_lock_q.pop_front();
        lock_pend = 1'b1;
      end
    end
  end

  // Driver: one reference pulse carrying err; ref_rise lands two cycles later.
  task automatic pulse_ref(input int err);
    @(posedge clk); #1;
    pd_error = W'(err);
    reference = 1'b1;
    model_update(err, cyc + 2 + S + 2);
    repeat (4) @(posedge clk);
    #1 reference = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", int'(ctrl_word), INIT);
    check("rst_valid", int'(ctrl_valid), 0);
    check("rst_sat", int'(saturated), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_state", int'(state), 0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);

    // Reset asserted mid-SETTLE aborts the pending update
    @(posedge clk); #1;
    pd_error = W'(9);
    reference = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_settle_state", int'(state), 2);
    reset_n = 1'b0;
    enable = 1'b0;
    reference = 1'b0;
    model_reset();
    #1;
    check("async_rst_word", int'(ctrl_word), INIT);
    check("async_rst_state", int'(state), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", int'(state), 0);
    check("post_rst_word", int'(ctrl_word), INIT);
    enable = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("armed_no_update", int'(state), 1);

    // Most negative error from a clean integrator
    pulse_ref(-16);
    #1 check("neg_extreme_word", int'(ctrl_word), 1904);
    check("neg_extreme_sat", int'(saturated), 0);
    do_reset();

    // Basic PI steps
    pulse_ref(3);
    #1 check("pi_step1_word", int'(ctrl_word), 2075);
    pulse_ref(0);
    #1 check("pi_step2_word", int'(ctrl_word), 2051);

    // Drive into the high clamp, stay there, then reverse
    for (int k = 0; k < 200 && m_word != CMAX; k++) pulse_ref(15);
    repeat (3) pulse_ref(15);
    pulse_ref(-15);

    // Second reference rise during SETTLE is ignored
    @(posedge clk); #1;
    pd_error = W'(5);
    reference = 1'b1;
    model_update(5, cyc + 2 + S + 2);
    @(posedge clk); #1 reference = 1'b0;
    @(posedge clk); #1 reference = 1'b1;
    @(posedge clk); #1 reference = 1'b0;
    repeat (10) @(posedge clk);

    // Enable dropped during SAMPLE: back to IDLE with outputs held
    @(posedge clk); #1;
    pd_error = W'(7);
    reference = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drop_in_sample_state", int'(state), 3);
    enable = 1'b0;
    m_lock = 0;
    @(posedge clk); #1;
    check("drop_idle_state", int'(state), 0);
    check("drop_word_held", int'(ctrl_word), m_word);
    check("drop_sat_held", int'(saturated), m_sat);
    reference = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    repeat (4) @(posedge clk);
    pulse_ref(2);

    // Low clamp
    for (int k = 0; k < 200 && m_word != 0; k++) pulse_ref(-16);
    repeat (2) pulse_ref(-16);
    pulse_ref(14);

    // Lock sequence: eight small errors then one outside the threshold
    do_reset();
    for (int k = 0; k < LCNT; k++) pulse_ref(int'($urandom_range(0, 2)) - 1);
    pulse_ref(2);

    // Randomised errors
    for (int k = 0; k < 80; k++) pulse_ref(int'($urandom_range(0, 31)) - 16);

    repeat (20) @(posedge clk);
    check("queue_drained", exp_word_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
